multi_cycle_ctrl: RTL



---
 rtl/multi_cycle_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM (IF/ID/EX/MEM/WB) with a shared mem_ack handshake and an ack timeout.
// Optional single-step mode: define MULTI_CYCLE_CTRL_STEP_EN to add the step/halted ports and the HALT state.
module multi_cycle_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4
) (
  input  logic        clk,
  input  logic        resetn,
`ifdef MULTI_CYCLE_CTRL_STEP_EN
  input  logic        step,
`endif
  input  logic        dec_valid,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_wb,
  input  logic        mem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_wen,
  output logic        pc_wen,
  output logic        rf_wen,
  output logic [2:0]  stage,
  output logic [31:0] instr_cnt,
  output logic        err,
  output logic        busy
`ifdef MULTI_CYCLE_CTRL_STEP_EN
  ,
  output logic        halted
`endif
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_ERR  = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(ACK_TIMEOUT);
  localparam bit              TO_EN  = (ACK_TIMEOUT != 0);

  state_t          state_q, state_d;
  logic [TO_W-1:0] wait_q, wait_d;
  logic [31:0]     instr_cnt_q, instr_cnt_d;
  logic            err_q;
  logic            retire_s;
  logic            imem_req_s, dmem_req_s, dmem_we_s, ir_wen_s, pc_wen_s, rf_wen_s;

  // State, wait counter, retire counter and sticky error register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IF;
      wait_q      <= '0;
      instr_cnt_q <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      instr_cnt_q <= instr_cnt_d;
      err_q       <= (state_d == S_ERR);
    end
  end

  // Next-state, wait-counter and enable decode
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    retire_s    = 1'b0;
    imem_req_s  = 1'b0;
    dmem_req_s  = 1'b0;
    dmem_we_s   = 1'b0;
    ir_wen_s    = 1'b0;
    pc_wen_s    = 1'b0;
    rf_wen_s    = 1'b0;
    instr_cnt_d = instr_cnt_q;

    case (state_q)
      S_IF: begin
        imem_req_s = 1'b1;
        if (mem_ack) begin
          ir_wen_s = 1'b1;
          state_d  = S_ID;
        end else if (TO_EN && (wait_q == TO_MAX)) begin
          state_d = S_ERR;
        end else if (wait_q != TO_MAX) begin
          wait_d = wait_q + TO_W'(1);
        end else begin
          wait_d = wait_q;
        end
      end
      S_ID: begin
        if (dec_valid) begin
          state_d = S_EX;
        end else begin
          state_d = S_ERR;
        end
      end
      S_EX: begin
        // A set store flag wins over load, so both-set is handled as a store in MEM.
        if (dec_load || dec_store) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else if (dec_wb) begin
          state_d = S_WB;
        end else begin
          retire_s = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = dec_store;
        if (mem_ack) begin
          if (dec_store) begin
            retire_s = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (TO_EN && (wait_q == TO_MAX)) begin
          state_d = S_ERR;
        end else if (wait_q != TO_MAX) begin
          wait_d = wait_q + TO_W'(1);
        end else begin
          wait_d = wait_q;
        end
      end
      S_WB: begin
        rf_wen_s = 1'b1;
        retire_s = 1'b1;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
`ifdef MULTI_CYCLE_CTRL_STEP_EN
      S_HALT: begin
        if (step) begin
          state_d = S_IF;
          wait_d  = '0;
        end else begin
          state_d = S_HALT;
        end
      end
`endif
      default: begin
        state_d = S_ERR;
      end
    endcase

    if (retire_s) begin
      pc_wen_s    = 1'b1;
      instr_cnt_d = instr_cnt_q + 32'd1;
      wait_d      = '0;
`ifdef MULTI_CYCLE_CTRL_STEP_EN
      state_d     = S_HALT;
`else
      state_d     = S_IF;
`endif
    end else begin
      instr_cnt_d = instr_cnt_q;
    end
  end

  // The reset cycle must not leak any enable, including the Mealy ir_wen.
  assign imem_req  = resetn & imem_req_s;
  assign dmem_req  = resetn & dmem_req_s;
  assign dmem_we   = resetn & dmem_we_s;
  assign ir_wen    = resetn & ir_wen_s;
  assign pc_wen    = resetn & pc_wen_s;
  assign rf_wen    = resetn & rf_wen_s;
  assign stage     = state_q;
  assign instr_cnt = instr_cnt_q;
  assign err       = err_q;
  assign busy      = (state_q != S_ERR) && (state_q != S_HALT);
`ifdef MULTI_CYCLE_CTRL_STEP_EN
  assign halted    = (state_q == S_HALT);
`endif

endmodule
